fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1c000000, the first fetch address after reset.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 2, the maximum number of accepted requests awaiting data_ok (>=1).
REQ-003 SHALL have parameter QDEPTH, default 4, the instruction queue entry count (power of 2, >=2).
REQ-004 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset; one clock, all state updates on posedge clk.
REQ-005 SHALL have ports: out_ready in 1 decode can accept; out_valid out 1 head entry valid; PC_out out 32 head PC; inst_out out 32 head instruction.
REQ-006 SHALL have ports: has_exception_out out 1; ecode_out out 6; esubcode_out out 9 (head entry exception fields).
REQ-007 SHALL have ports: ex_flush in 1; ex_entry in 32; ertn_flush in 1; ertn_entry in 32; br_taken in 1; br_target in 32; br_stall in 1.
REQ-008 SHALL have SRAM-like ports: req out 1; wr out 1; size out 2; addr out 32; wstrb out 4; wdata out 32; addr_ok in 1; data_ok in 1; rdata in 32.

Function
REQ-009 SHALL tie wr=0, size=2'b10, wstrb=0, wdata=0.
REQ-010 SHALL hold fetch PC fpc; addr = fpc.
REQ-011 SHALL assert req iff: no redirect this cycle, !br_stall, !halt, fpc[1:0]==0, outstanding<MAX_OUTSTANDING, outstanding+queue_count<QDEPTH (credit rule; queue never overflows).
REQ-012 SHALL treat req&&addr_ok as an accept: push fpc into an in-order pending-PC FIFO (depth MAX_OUTSTANDING), fpc<=fpc+4 (mod 2^32, wraps), outstanding+1.
REQ-013 SHALL on data_ok pop pending PC, outstanding-1; if discard_cnt>0 drop the data and decrement discard_cnt, else push {pc, rdata, exc=0} to queue tail.
REQ-014 SHALL handle accept and data_ok in the same cycle: outstanding unchanged, FIFO push and pop both occur.
REQ-015 SHALL ignore data_ok when outstanding==0 (no state change).
REQ-016 SHALL on fpc[1:0]!=0, !halt, outstanding==0, credit available and no redirect: push {fpc, inst=0, exc=1, ecode=6'h8, esub=9'h0} to queue, set halt; no bus request for that PC.
REQ-017 SHALL redirect priority ex_flush > ertn_flush > br_taken; target ex_entry / ertn_entry / br_target.
REQ-018 SHALL on ex_flush or ertn_flush: fpc<=target, clear queue, clear halt, discard_cnt <= all accepted-not-returned requests at end of cycle (including an accept this cycle); data_ok this cycle is dropped.
REQ-019 SHALL apply identical redirect action on br_taken (without ex_flush/ertn_flush).
REQ-020 SHALL force req=0 and out_valid=0 in any redirect cycle.
REQ-021 SHALL drive out_valid = queue non-empty; PC_out/inst_out/exception outputs from head entry (registered storage, no rdata bypass).
REQ-022 SHALL pop head when out_valid&&out_ready; simultaneous push and pop keeps count, including when full.
REQ-023 SHALL have minimum latency: accept in cycle t, data_ok in cycle t+k (k>=1) -> out_valid in cycle t+k+1.
REQ-024 SHALL leave br_stall affecting only new requests; in-flight responses and queue pops continue.

Reset
REQ-025 SHALL on rst set fpc=RESET_PC, queue empty, outstanding=0, discard_cnt=0, halt=0.
REQ-026 SHALL on rst drive out_valid=0, req=0, PC_out=0, inst_out=0, has_exception_out=0, ecode_out=0, esubcode_out=0.
REQ-027 SHALL abandon in-flight requests when rst is asserted mid-operation; the bus is reset with the block.

Verification
REQ-028 SHALL cover streaming: addr_ok=1, data_ok one cycle later, out_ready=1 -> PCs 1c000000,1c000004,1c000008 out in order with matching rdata, 2 outstanding sustained.
REQ-029 SHALL cover backpressure: out_ready=0 -> queue fills to 4, req drops at outstanding+count==4, no entry lost after out_ready=1.
REQ-030 SHALL cover redirect with 2 outstanding: br_taken to 1c000100 -> two following data_ok dropped, next out_valid shows PC 1c000100.
REQ-031 SHALL cover simultaneous ex_flush(entry 1c008000) and br_taken -> fpc=1c008000, queue empty next cycle.
REQ-032 SHALL cover ADEF: br_target 1c000102 -> one entry PC 1c000102, has_exception_out=1, ecode_out=6'h8, no req until ertn_flush.
REQ-033 SHALL cover rst mid-fetch with entries queued -> out_valid=0 next cycle, first req addr 1c000000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end for an SRAM-like bus.
// Issues word reads from the fetch PC, tracks in-flight requests in order,
// collects returned words into an instruction queue, and redirects on
// exception, ertn or taken branch. Misaligned fetch PCs produce an ADEF
// queue entry and stall fetch until the next redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          QDEPTH          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] PC_out,
  output logic [31:0] inst_out,
  output logic        has_exception_out,
  output logic [5:0]  ecode_out,
  output logic [8:0]  esubcode_out,
  input  logic        ex_flush,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_entry,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(QDEPTH);
  localparam int CW = QW + 1;
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0] PLAST = PW'(MAX_OUTSTANDING - 1);

  logic [31:0]   fpc;
  logic          halt;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard_cnt;

  // PCs of accepted requests, oldest first
  logic [31:0]   pend_pc [MAX_OUTSTANDING];
  logic [PW-1:0] pend_wr;
  logic [PW-1:0] pend_rd;

  // instruction queue storage
  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_inst  [QDEPTH];
  logic          q_exc   [QDEPTH];
  logic [5:0]    q_ecode [QDEPTH];
  logic [8:0]    q_esub  [QDEPTH];
  logic [QW-1:0] q_head;
  logic [QW-1:0] q_tail;
  logic [CW-1:0] q_count;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          credit;
  logic          accept;
  logic          resp;
  logic          deliver;
  logic          adef;
  logic          push;
  logic          pop;
  logic [31:0]   push_pc;
  logic [31:0]   push_inst;

  assign wr    = 1'b0;
  assign size  = 2'b10;
  assign wstrb = 4'b0000;
  assign wdata = 32'h0;
  assign addr  = fpc;

  // request gating, redirect selection and queue push/pop decisions
  always_comb begin
    redirect    = ex_flush | ertn_flush | br_taken;
    redirect_pc = ex_flush ? ex_entry : (ertn_flush ? ertn_entry : br_target);
    // a slot is reserved in the queue for every in-flight request
    credit      = (32'(outstanding) + 32'(q_count)) < 32'(QDEPTH);
    req         = !redirect && !br_stall && !halt && (fpc[1:0] == 2'b00) &&
                  (32'(outstanding) < 32'(MAX_OUTSTANDING)) && credit;
    accept      = req && addr_ok;
    resp        = data_ok && (outstanding != '0);
    deliver     = resp && !redirect && (discard_cnt == '0);
    // misaligned PC: wait until the bus is idle so the fault stays in order
    adef        = !redirect && (fpc[1:0] != 2'b00) && !halt &&
                  (outstanding == '0) && credit;
    push        = deliver || adef;
    out_valid   = (q_count != '0) && !redirect;
    pop         = out_valid && out_ready;
    push_pc     = adef ? fpc : pend_pc[pend_rd];
    push_inst   = adef ? 32'h0 : rdata;
  end

  // head entry drives decode; zeros when the queue is empty
  always_comb begin
    PC_out            = 32'h0;
    inst_out          = 32'h0;
    has_exception_out = 1'b0;
    ecode_out         = 6'h0;
    esubcode_out      = 9'h0;
    if (q_count != '0) begin
      PC_out            = q_pc[q_head];
      inst_out          = q_inst[q_head];
      has_exception_out = q_exc[q_head];
      ecode_out         = q_ecode[q_head];
      esubcode_out      = q_esub[q_head];
    end
  end

  // fetch PC, outstanding tracking, discard accounting and queue updates
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc         <= RESET_PC;
      halt        <= 1'b0;
      outstanding <= '0;
      discard_cnt <= '0;
      pend_wr     <= '0;
      pend_rd     <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
    end else begin
      if (accept) begin
        pend_pc[pend_wr] <= fpc;
        pend_wr          <= (pend_wr == PLAST) ? '0 : pend_wr + PW'(1);
      end
      if (resp) pend_rd <= (pend_rd == PLAST) ? '0 : pend_rd + PW'(1);
      if (accept && !resp) outstanding <= outstanding + OW'(1);
      else if (resp && !accept) outstanding <= outstanding - OW'(1);

      if (redirect) begin
        // no accept can happen here, so survivors are outstanding minus this response
        fpc         <= redirect_pc;
        halt        <= 1'b0;
        q_head      <= '0;
        q_tail      <= '0;
        q_count     <= '0;
        discard_cnt <= resp ? outstanding - OW'(1) : outstanding;
      end else begin
        if (accept) fpc <= fpc + 32'd4;
        if (adef) halt <= 1'b1;
        if (resp && (discard_cnt != '0)) discard_cnt <= discard_cnt - OW'(1);
        if (push) begin
          q_pc[q_tail]    <= push_pc;
          q_inst[q_tail]  <= push_inst;
          q_exc[q_tail]   <= adef;
          q_ecode[q_tail] <= adef ? 6'h8 : 6'h0;
          q_esub[q_tail]  <= 9'h0;
          q_tail          <= q_tail + QW'(1);
        end
        if (pop) q_head <= q_head + QW'(1);
        if (push && !pop) q_count <= q_count + CW'(1);
        else if (pop && !push) q_count <= q_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based model of the fetch unit's rules.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h1c000000;
  localparam int MAXO = 2;
  localparam int QD   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] PC_out;
  logic [31:0] inst_out;
  logic        has_exception_out;
  logic [5:0]  ecode_out;
  logic [8:0]  esubcode_out;
  logic        ex_flush;
  logic [31:0] ex_entry;
  logic        ertn_flush;
  logic [31:0] ertn_entry;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_stall;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .MAX_OUTSTANDING(MAXO), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .out_ready(out_ready), .out_valid(out_valid),
    .PC_out(PC_out), .inst_out(inst_out), .has_exception_out(has_exception_out),
    .ecode_out(ecode_out), .esubcode_out(esubcode_out),
    .ex_flush(ex_flush), .ex_entry(ex_entry), .ertn_flush(ertn_flush),
    .ertn_entry(ertn_entry), .br_taken(br_taken), .br_target(br_target),
    .br_stall(br_stall), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [5:0]  ecode;
    logic [8:0]  esub;
  } ent_t;

  // model state
  ent_t        m_q[$];
  logic [31:0] m_pend[$];
  logic [31:0] m_fpc;
  bit          m_halt;
  int          m_disc;

  int checks = 0;
  int errors = 0;

  // memory contents seen by the bus: a fixed scramble of the address
  function automatic logic [31:0] rfun(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3c3c1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    rst = 1'b0; out_ready = 1'b0;
    ex_flush = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
    ex_entry = 32'h0; ertn_entry = 32'h0; br_target = 32'h0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
  endtask

  // bus slave: responses return in order for the oldest accepted address
  task automatic drive_bus(input bit want_dok, input bit aok);
    addr_ok = aok;
    data_ok = want_dok;
    rdata   = (m_pend.size() > 0) ? rfun(m_pend[0]) : $urandom;
  endtask

  // called just after a negedge with inputs applied; checks, advances the model
  task automatic cyc(input bit do_chk);
    bit          redir, e_req, e_valid, acc, dok, pop, adef, credit;
    logic [31:0] tgt;
    ent_t        e;
    #1;
    redir   = ex_flush || ertn_flush || br_taken;
    tgt     = ex_flush ? ex_entry : (ertn_flush ? ertn_entry : br_target);
    credit  = (m_pend.size() + m_q.size()) < QD;
    e_req   = !redir && !br_stall && !m_halt && (m_fpc[1:0] == 2'b00) &&
              (m_pend.size() < MAXO) && credit;
    e_valid = (m_q.size() > 0) && !redir;
    if (do_chk) begin
      chk("req", 32'(req), 32'(e_req));
      chk("addr", addr, m_fpc);
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("bus_ctrl", {25'h0, wr, size, wstrb}, 32'h20);
      chk("wdata", wdata, 32'h0);
      if (m_q.size() > 0) begin
        chk("PC_out", PC_out, m_q[0].pc);
        chk("inst_out", inst_out, m_q[0].inst);
        chk("has_exception_out", 32'(has_exception_out), 32'(m_q[0].exc));
        chk("ecode_out", 32'(ecode_out), 32'(m_q[0].ecode));
        chk("esubcode_out", 32'(esubcode_out), 32'(m_q[0].esub));
      end
    end
    if (rst) begin
      m_fpc = RPC; m_q.delete(); m_pend.delete(); m_halt = 0; m_disc = 0;
    end else begin
      acc  = e_req && addr_ok;
      dok  = data_ok && (m_pend.size() > 0);
      pop  = e_valid && out_ready;
      adef = !redir && (m_fpc[1:0] != 2'b00) && !m_halt && (m_pend.size() == 0) && credit;
      if (pop) void'(m_q.pop_front());
      if (dok) begin
        e.pc = m_pend.pop_front();
        if (!redir) begin
          if (m_disc > 0) m_disc--;
          else begin
            e.inst = rfun(e.pc); e.exc = 1'b0; e.ecode = 6'h0; e.esub = 9'h0;
            m_q.push_back(e);
          end
        end
      end
      if (adef) begin
        e.pc = m_fpc; e.inst = 32'h0; e.exc = 1'b1; e.ecode = 6'h8; e.esub = 9'h0;
        m_q.push_back(e);
        m_halt = 1;
      end
      if (acc) begin
        m_pend.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
      if (redir) begin
        m_q.delete(); m_halt = 0; m_fpc = tgt; m_disc = m_pend.size();
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input bit do_chk);
    set_idle();
    rst = 1'b1;
    drive_bus(1'b0, 1'b0);
    cyc(do_chk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rtarget();
    logic [31:0] t;
    t = {16'h1c00, 14'($urandom), 2'b00};
    if (($urandom % 8) == 0) t[1:0] = 2'($urandom_range(1, 3));
    if (($urandom % 16) == 0) t = 32'hfffffff4;
    return t;
  endfunction

  initial begin
    bit found;
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    do_reset(1'b0);

    // streaming: reset values, first address, single-cycle responses
    for (int i = 0; i < 8; i++) begin
      set_idle(); out_ready = 1'b1;
      drive_bus(m_pend.size() > 0, 1'b1);
      #1;
      if (i == 0) begin
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_PC_out", PC_out, 32'h0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_exc", {23'h0, has_exception_out, ecode_out, esubcode_out[1:0]}, 32'h0);
        chk("first_req", 32'(req), 32'h1);
        chk("first_addr", addr, 32'h1c000000);
      end
      if (i >= 2 && i <= 4) begin
        chk("stream_valid", 32'(out_valid), 32'h1);
        chk("stream_pc", PC_out, 32'h1c000000 + 32'(4 * (i - 2)));
        chk("stream_inst", inst_out, rfun(32'h1c000000 + 32'(4 * (i - 2))));
      end
      cyc(1'b1);
    end

    // backpressure: queue fills to four, request drops, nothing lost
    do_reset(1'b1);
    for (int i = 0; i < 12; i++) begin
      set_idle(); drive_bus(m_pend.size() > 0, 1'b1);
      cyc(1'b1);
    end
    set_idle(); drive_bus(1'b0, 1'b1);
    #1;
    chk("bp_req_low", 32'(req), 32'h0);
    chk("bp_addr", addr, 32'h1c000010);
    for (int i = 0; i < 4; i++) begin
      set_idle(); out_ready = 1'b1; drive_bus(1'b0, 1'b0);
      #1;
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_pc", PC_out, 32'h1c000000 + 32'(4 * i));
      cyc(1'b1);
    end
    // refill, then reset mid-fetch
    for (int i = 0; i < 6; i++) begin
      set_idle(); drive_bus(m_pend.size() > 0, 1'b1);
      cyc(1'b1);
    end
    do_reset(1'b1);
    set_idle(); drive_bus(1'b0, 1'b1);
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_req", 32'(req), 32'h1);
    chk("rst_mid_addr", addr, 32'h1c000000);
    cyc(1'b1);

    // branch redirect with two requests in flight
    do_reset(1'b1);
    for (int i = 0; i < 2; i++) begin
      set_idle(); out_ready = 1'b1; drive_bus(1'b0, 1'b1);
      cyc(1'b1);
    end
    set_idle(); out_ready = 1'b1; br_taken = 1'b1; br_target = 32'h1c000100;
    drive_bus(1'b0, 1'b1);
    #1;
    chk("redir_req_low", 32'(req), 32'h0);
    cyc(1'b1);
    for (int i = 0; i < 2; i++) begin
      set_idle(); out_ready = 1'b1; drive_bus(1'b1, 1'b0);
      cyc(1'b1);
    end
    found = 0;
    for (int i = 0; i < 12; i++) begin
      set_idle(); out_ready = 1'b1; drive_bus(m_pend.size() > 0, 1'b1);
      #1;
      if (!found && out_valid) begin
        found = 1;
        chk("redir_first_pc", PC_out, 32'h1c000100);
      end
      cyc(1'b1);
    end
    chk("redir_seen", 32'(found), 32'h1);

    // simultaneous ex_flush and br_taken: exception wins
    for (int i = 0; i < 4; i++) begin
      set_idle(); drive_bus(m_pend.size() > 0, 1'b1);
      cyc(1'b1);
    end
    set_idle(); ex_flush = 1'b1; ex_entry = 32'h1c008000;
    br_taken = 1'b1; br_target = 32'h1c000200; drive_bus(1'b0, 1'b1);
    cyc(1'b1);
    set_idle(); drive_bus(1'b0, 1'b0);
    #1;
    chk("exf_addr", addr, 32'h1c008000);
    chk("exf_empty", 32'(out_valid), 32'h0);
    cyc(1'b1);

    // misaligned target: ADEF entry, fetch halted until ertn
    do_reset(1'b1);
    set_idle(); br_taken = 1'b1; br_target = 32'h1c000102; drive_bus(1'b0, 1'b1);
    cyc(1'b1);
    for (int i = 0; i < 5; i++) begin
      set_idle(); drive_bus(1'b0, 1'b1);
      #1;
      chk("adef_req_low", 32'(req), 32'h0);
      if (i >= 1) begin
        chk("adef_valid", 32'(out_valid), 32'h1);
        chk("adef_pc", PC_out, 32'h1c000102);
        chk("adef_exc", 32'(has_exception_out), 32'h1);
        chk("adef_ecode", 32'(ecode_out), 32'h8);
        chk("adef_inst", inst_out, 32'h0);
      end
      cyc(1'b1);
    end
    set_idle(); ertn_flush = 1'b1; ertn_entry = 32'h1c000000; drive_bus(1'b0, 1'b1);
    cyc(1'b1);
    set_idle(); drive_bus(1'b0, 1'b1);
    #1;
    chk("ertn_req", 32'(req), 32'h1);
    chk("ertn_addr", addr, 32'h1c000000);
    cyc(1'b1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      set_idle();
      rst        = ($urandom % 300) == 0;
      out_ready  = ($urandom % 10) < 7;
      br_stall   = ($urandom % 6) == 0;
      ex_flush   = ($urandom % 40) == 0;
      ex_entry   = rtarget();
      ertn_flush = ($urandom % 35) == 0;
      ertn_entry = rtarget();
      br_taken   = ($urandom % 15) == 0;
      br_target  = rtarget();
      drive_bus(($urandom % 10) < 6, ($urandom % 10) < 7);
      cyc(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
